// File: rtl/scroll_pkg.sv
// Shared state encoding, direction codes and default screen bounds for the VRAM region walkers.
package scroll_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WRITE = 3'd2,
      S_FILL  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam int DEF_TOP    = 0;
   localparam int DEF_BOTTOM = 16;
   localparam int DEF_LEFT   = 0;
   localparam int DEF_RIGHT  = 59;

endpackage

// File: rtl/scroll_walker.sv
// Row/col cursor over a rectangular window: load jumps to the first cell, step advances one cell.
// Rows run top->bottom (up) or bottom->top (down); columns always left->right; o_last flags the final cell.
module scroll_walker
   import scroll_pkg::*;
#(
   parameter int ROW_W = 5,
   parameter int COL_W = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_dir,
   input  logic [ROW_W-1:0] i_top,
   input  logic [ROW_W-1:0] i_bottom,
   input  logic [COL_W-1:0] i_left,
   input  logic [COL_W-1:0] i_right,
   output logic [ROW_W-1:0] o_row,
   output logic [ROW_W-1:0] o_row_nxt,
   output logic [COL_W-1:0] o_col,
   output logic             o_last
);

   logic [ROW_W-1:0] row_start, row_end;
   logic [COL_W-1:0] col_nxt;

   assign row_start = (i_dir == DIR_DOWN) ? i_bottom : i_top;
   assign row_end   = (i_dir == DIR_DOWN) ? i_top : i_bottom;
   assign o_last    = (o_col == i_right) && (o_row == row_end);

   // o_row_nxt is exposed so the owner can classify the upcoming cell one cycle early.
   always_comb begin
      o_row_nxt = o_row;
      col_nxt   = o_col;
      if (i_load) begin
         o_row_nxt = row_start;
         col_nxt   = i_left;
      end else if (i_step) begin
         if (o_col == i_right) begin
            col_nxt   = i_left;
            o_row_nxt = (i_dir == DIR_DOWN) ? o_row - ROW_W'(1) : o_row + ROW_W'(1);
         end else begin
            col_nxt = o_col + COL_W'(1);
         end
      end
   end

   always_ff @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_row <= '0;
         o_col <= '0;
      end else begin
         o_row <= o_row_nxt;
         o_col <= col_nxt;
      end
   end

endmodule

// File: rtl/scroll_region.sv
// Scrolls a rectangular VRAM window up/down by N lines and fills vacated lines; 2 cycles per copied cell, 1 per fill.
// State advances on the falling clock edge so the VRAM sees stable address/data on its rising edge.
module scroll_region
   import scroll_pkg::*;
#(
   parameter int ROW_W  = 5,
   parameter int COL_W  = 6,
   parameter int DATA_W = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_start,
   input  logic                   i_dir,
   input  logic [ROW_W-1:0]       i_top,
   input  logic [ROW_W-1:0]       i_bottom,
   input  logic [COL_W-1:0]       i_left,
   input  logic [COL_W-1:0]       i_right,
   input  logic [ROW_W-1:0]       i_lines,
   input  logic [DATA_W-1:0]      i_fill,
   output logic                   o_running,
   output logic                   o_done,
   output logic [ROW_W+COL_W-1:0] o_vram_addr,
   output logic                   o_vram_w,
   output logic                   o_vram_ce,
   input  logic [DATA_W-1:0]      i_vram_dout,
   output logic [DATA_W-1:0]      o_vram_din
);

   state_t state, state_nxt;

   logic              dir_q;
   logic [ROW_W-1:0]  top_q, bottom_q, lines_q;
   logic [COL_W-1:0]  left_q, right_q;
   logic [DATA_W-1:0] fill_q, data_q;

   logic             idle, load, step, last, bad_args, nxt_fill;
   logic             cur_dir;
   logic [ROW_W-1:0] cur_top, cur_bottom, cur_lines;
   logic [COL_W-1:0] cur_left, cur_right;
   logic [ROW_W-1:0] row, row_nxt, src_row;
   logic [COL_W-1:0] col;
   logic [ROW_W:0]   nrow_x, top_x, bot_x, lines_x;

   // While idle the raw inputs drive the walker so the first cell is known on the start edge.
   assign idle       = (state == S_IDLE);
   assign cur_dir    = idle ? i_dir    : dir_q;
   assign cur_top    = idle ? i_top    : top_q;
   assign cur_bottom = idle ? i_bottom : bottom_q;
   assign cur_left   = idle ? i_left   : left_q;
   assign cur_right  = idle ? i_right  : right_q;
   assign cur_lines  = idle ? i_lines  : lines_q;

   assign bad_args = (i_top > i_bottom) || (i_left > i_right) || (i_lines == '0);
   assign load     = idle && i_start;
   assign step     = ((state == S_WRITE) || (state == S_FILL)) && !last;

   // One extra bit so dst+lines never wraps back into the window.
   assign nrow_x   = {1'b0, row_nxt};
   assign top_x    = {1'b0, cur_top};
   assign bot_x    = {1'b0, cur_bottom};
   assign lines_x  = {1'b0, cur_lines};
   assign nxt_fill = (cur_dir == DIR_UP) ? (nrow_x + lines_x > bot_x) : (nrow_x < top_x + lines_x);
   assign src_row  = (dir_q == DIR_UP) ? row + lines_q : row - lines_q;

   scroll_walker #(.ROW_W(ROW_W), .COL_W(COL_W)) u_walker (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_load    (load),
      .i_step    (step),
      .i_dir     (cur_dir),
      .i_top     (cur_top),
      .i_bottom  (cur_bottom),
      .i_left    (cur_left),
      .i_right   (cur_right),
      .o_row     (row),
      .o_row_nxt (row_nxt),
      .o_col     (col),
      .o_last    (last)
   );

   always_ff @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dir_q    <= DIR_UP;
         top_q    <= '0;
         bottom_q <= '0;
         left_q   <= '0;
         right_q  <= '0;
         lines_q  <= '0;
         fill_q   <= '0;
         data_q   <= '0;
      end else begin
         if (load) begin
            dir_q    <= i_dir;
            top_q    <= i_top;
            bottom_q <= i_bottom;
            left_q   <= i_left;
            right_q  <= i_right;
            lines_q  <= i_lines;
            fill_q   <= i_fill;
         end
         if (state == S_READ) data_q <= i_vram_dout;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_start) state_nxt = bad_args ? S_DONE : (nxt_fill ? S_FILL : S_READ);
         S_READ:  state_nxt = S_WRITE;
         S_WRITE,
         S_FILL:  state_nxt = last ? S_DONE : (nxt_fill ? S_FILL : S_READ);
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_running   = 1'b0;
      o_done      = 1'b0;
      o_vram_ce   = 1'b0;
      o_vram_w    = 1'b0;
      o_vram_addr = '0;
      o_vram_din  = '0;
      case (state)
         S_READ: begin
            o_running   = 1'b1;
            o_vram_ce   = 1'b1;
            o_vram_addr = {src_row, col};
         end
         S_WRITE: begin
            o_running   = 1'b1;
            o_vram_ce   = 1'b1;
            o_vram_w    = 1'b1;
            o_vram_addr = {row, col};
            o_vram_din  = data_q;
         end
         S_FILL: begin
            o_running   = 1'b1;
            o_vram_ce   = 1'b1;
            o_vram_w    = 1'b1;
            o_vram_addr = {row, col};
            o_vram_din  = fill_q;
         end
         S_DONE:  o_done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_scroll_region.sv
// Bench for scroll_region: VRAM model plus a snapshot-based reference of the scrolled window.
module tb_scroll_region;

   localparam int ROW_W = 5;
   localparam int COL_W = 6;
   localparam int DATA_W = 8;
   localparam int NCELL = 2048;
   localparam int LIMIT = 6000;

   logic                   i_clk = 1'b0;
   logic                   i_rst_n = 1'b0;
   logic                   i_start = 1'b0;
   logic                   i_dir = 1'b0;
   logic [ROW_W-1:0]       i_top = '0;
   logic [ROW_W-1:0]       i_bottom = '0;
   logic [COL_W-1:0]       i_left = '0;
   logic [COL_W-1:0]       i_right = '0;
   logic [ROW_W-1:0]       i_lines = '0;
   logic [DATA_W-1:0]      i_fill = '0;
   logic                   o_running, o_done, o_vram_w, o_vram_ce;
   logic [ROW_W+COL_W-1:0] o_vram_addr;
   logic [DATA_W-1:0]      i_vram_dout;
   logic [DATA_W-1:0]      o_vram_din;

   int n_checks = 0;
   int n_fail = 0;
   int pl_mode = 0;

   logic [7:0] mem  [NCELL];
   logic [7:0] old  [NCELL];
   logic [7:0] expm [NCELL];

   scroll_region #(.ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_dir       (i_dir),
      .i_top       (i_top),
      .i_bottom    (i_bottom),
      .i_left      (i_left),
      .i_right     (i_right),
      .i_lines     (i_lines),
      .i_fill      (i_fill),
      .o_running   (o_running),
      .o_done      (o_done),
      .o_vram_addr (o_vram_addr),
      .o_vram_w    (o_vram_w),
      .o_vram_ce   (o_vram_ce),
      .i_vram_dout (i_vram_dout),
      .o_vram_din  (o_vram_din)
   );

   always #5 i_clk = ~i_clk;

   // Single-port VRAM with registered read data; also handles bulk preloads.
   always @(posedge i_clk) begin
      if (pl_mode == 1) begin
         for (int a = 0; a < NCELL; a++) mem[a] <= 8'($urandom);
      end else if (pl_mode == 2) begin
         for (int a = 0; a < NCELL; a++) mem[a] <= 8'(a / 64);
      end else if (o_vram_ce) begin
         if (o_vram_w) mem[o_vram_addr] <= o_vram_din;
         else          i_vram_dout <= mem[o_vram_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic preload(input int mode);
      @(posedge i_clk);
      pl_mode = mode;
      @(posedge i_clk);
      @(posedge i_clk);
      pl_mode = 0;
      @(posedge i_clk);
   endtask

   task automatic drive_args(input bit dir, input int top, input int bottom, input int left,
                             input int right, input int lines, input int fill);
      i_dir    = dir;
      i_top    = ROW_W'(top);
      i_bottom = ROW_W'(bottom);
      i_left   = COL_W'(left);
      i_right  = COL_W'(right);
      i_lines  = ROW_W'(lines);
      i_fill   = DATA_W'(fill);
   endtask

   task automatic run_op(input string name, input bit dir, input int top, input int bottom,
                         input int left, input int right, input int lines, input int fill,
                         input bit poke);
      int exp_busy = 0, exp_reads = 0;
      int busy = 0, reads = 0, dones = 0, done_cyc = -1, proto = 0, bad = 0, cyc = 0;
      int src;
      bit valid;
      #1;
      for (int a = 0; a < NCELL; a++) begin
         old[a]  = mem[a];
         expm[a] = mem[a];
      end
      // Reference: every window cell takes the pre-scroll value lines away, or fill if that is outside.
      valid = (top <= bottom) && (left <= right) && (lines != 0);
      if (valid) begin
         for (int r = top; r <= bottom; r++) begin
            for (int c = left; c <= right; c++) begin
               src = dir ? r - lines : r + lines;
               if (src >= top && src <= bottom) begin
                  expm[r*64+c] = old[src*64+c];
                  exp_busy += 2;
                  exp_reads++;
               end else begin
                  expm[r*64+c] = 8'(fill);
                  exp_busy += 1;
               end
            end
         end
      end
      @(posedge i_clk);
      drive_args(dir, top, bottom, left, right, lines, fill);
      i_start = 1'b1;
      while (cyc < LIMIT && !(done_cyc >= 0 && cyc >= done_cyc + 3)) begin
         @(posedge i_clk);
         cyc++;
         if (cyc == 1) i_start = 1'b0;
         if (poke && cyc == 5) begin
            i_start = 1'b1;
            i_top   = '0;
            i_lines = ROW_W'(1);
            i_fill  = 8'hEE;
         end
         if (poke && cyc == 6) i_start = 1'b0;
         if (o_running) busy++;
         if (o_vram_ce && !o_vram_w) reads++;
         if (o_done) begin
            dones++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (o_vram_ce !== o_running || (o_vram_w && !o_running) || (o_done && o_running)) proto++;
      end
      for (int a = 0; a < NCELL; a++) if (mem[a] !== expm[a]) bad++;
      check({name, " vram_mismatches"}, bad, 0);
      check({name, " busy_cycles"}, busy, exp_busy);
      check({name, " read_cycles"}, reads, exp_reads);
      check({name, " done_pulses"}, dones, 1);
      check({name, " done_cycle"}, done_cyc, exp_busy + 1);
      check({name, " port_protocol"}, proto, 0);
   endtask

   initial begin
      int dones;
      int t, b, l, r;
      repeat (2) @(posedge i_clk);
      #1;
      check("reset running", o_running, 0);
      check("reset done", o_done, 0);
      check("reset vram_w", o_vram_w, 0);
      check("reset vram_ce", o_vram_ce, 0);
      check("reset addr", o_vram_addr, 0);
      check("reset din", o_vram_din, 0);
      @(posedge i_clk);
      i_rst_n = 1'b1;

      preload(2);
      run_op("full_up", 0, 0, 16, 0, 59, 1, 8'h00, 0);
      check("full_up row0", mem[0*64+7], 1);
      check("full_up row16", mem[16*64+59], 0);

      preload(1);
      run_op("win_down", 1, 3, 6, 10, 12, 2, 8'h20, 0);
      run_op("clear", 0, 2, 5, 0, 63, 5, 8'h55, 0);
      run_op("clear_down", 1, 10, 13, 5, 20, 31, 8'h3C, 0);
      run_op("invalid_rows", 0, 7, 3, 0, 10, 1, 8'h01, 0);
      run_op("invalid_cols", 1, 2, 9, 40, 39, 1, 8'h01, 0);
      run_op("zero_lines", 0, 2, 9, 0, 9, 0, 8'h01, 0);
      run_op("single_cell", 1, 9, 9, 30, 30, 3, 8'hAA, 0);
      run_op("bottom_edge", 0, 28, 31, 60, 63, 2, 8'h77, 0);
      run_op("busy_args", 0, 4, 20, 0, 63, 2, 8'h11, 1);

      // Reset during a long operation: everything drops at once and no completion is reported.
      preload(2);
      @(posedge i_clk);
      drive_args(0, 0, 16, 0, 59, 1, 8'h00);
      i_start = 1'b1;
      dones = 0;
      for (int c = 1; c < 100; c++) begin
         @(posedge i_clk);
         if (c == 1) i_start = 1'b0;
         if (o_done) dones++;
      end
      check("midrun running_before", o_running, 1);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("midrun running", o_running, 0);
      check("midrun vram_w", o_vram_w, 0);
      check("midrun vram_ce", o_vram_ce, 0);
      repeat (3) begin
         @(posedge i_clk);
         if (o_done) dones++;
      end
      i_rst_n = 1'b1;
      repeat (2) begin
         @(posedge i_clk);
         if (o_done) dones++;
      end
      check("midrun no_done", dones, 0);
      preload(1);
      run_op("after_reset", 1, 0, 31, 0, 63, 7, 8'h42, 0);

      for (int k = 0; k < 6; k++) begin
         t = $urandom_range(0, 31);
         b = $urandom_range(0, 31);
         l = $urandom_range(0, 63);
         r = $urandom_range(0, 63);
         if ($urandom_range(0, 7) != 0) begin
            if (b < t) begin int x = b; b = t; t = x; end
            if (r < l) begin int y = r; r = l; l = y; end
         end
         preload(1);
         run_op($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), t, b, l, r,
                $urandom_range(0, 12), $urandom_range(0, 255), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/scroll_region.md
Name: scroll_region

Overview:
Parametrised successor to the fixed full-screen scroller. It shifts a programmable rectangular text window up or down by N lines through the single-port character VRAM and fills the vacated lines with a programmable character. It sits between the terminal control FSM and the VRAM port mux; the control FSM owns the VRAM port while o_running is high.

Parameters:
ROW_W, 5, row address width (max 32 rows)
COL_W, 6, column address width (max 64 cols)
DATA_W, 8, VRAM data width
Note: there is no FILL parameter; the fill value comes from i_fill.

Ports:
i_clk  in  1  system clock; all state updates on falling edge (VRAM samples on rising edge)
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  start request; sampled only when idle
i_dir  in  1  0 = scroll up (content moves toward i_top), 1 = scroll down
i_top  in  ROW_W  first window row, inclusive
i_bottom  in  ROW_W  last window row, inclusive
i_left  in  COL_W  first window col, inclusive
i_right  in  COL_W  last window col, inclusive
i_lines  in  ROW_W  number of lines to shift
i_fill  in  DATA_W  character written into vacated lines
o_running  out  1  busy; VRAM port owned
o_done  out  1  one-cycle pulse after completion or rejection
o_vram_addr  out  ROW_W+COL_W  {row,col}
o_vram_w  out  1  write enable
o_vram_ce  out  1  chip enable
i_vram_dout  in  DATA_W  VRAM read data (registered inside VRAM)
o_vram_din  out  DATA_W  VRAM write data

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE. o_running, o_done, o_vram_w and o_vram_ce are 0. o_vram_addr and o_vram_din are 0.
- States: IDLE, READ, WRITE, FILL, DONE.
- IDLE + i_start: latch all i_* arguments. Later changes to the inputs have no effect.
  - If top>bottom, left>right or lines==0, go to DONE. No VRAM access.
  - Otherwise go to READ or FILL for the first cell.
- i_start while not IDLE: ignored. No queuing.
- Traversal order:
  - Up: dst rows run top→bottom.
  - Down: dst rows run bottom→top.
  - Columns always run left→right within a row.
- Source row arithmetic uses ROW_W+1 bits. There is no wrap-around.
  - Up: src = dst+lines. The cell is a fill cell if src > bottom.
  - Down: the cell is a fill cell if dst < top+lines; otherwise src = dst-lines.
  - lines ≥ window height means every cell is a fill cell (region clear).
- READ (1 cycle): addr={src,col}, ce=1, w=0. Next state is WRITE.
- WRITE (1 cycle): capture i_vram_dout into a data register on entry. addr={dst,col}, ce=1, w=1, din=data register.
- FILL (1 cycle): addr={dst,col}, ce=1, w=1, din=latched fill.
- After WRITE or FILL:
  - If dst is the last cell (end row, col=right), go to DONE.
  - Otherwise advance the cell and go to READ or FILL.
- DONE (1 cycle): o_running=0, o_done=1, then IDLE.
- o_running is high in READ, WRITE and FILL only. o_vram_ce equals o_running. o_vram_w is high only in WRITE and FILL.
- Busy cycles = 2·copy_cells + fill_cells. o_done rises one cycle after the last write.
- Reset mid-operation: abort immediately with no o_done. VRAM is left partially scrolled; this is acceptable.
- Single-cell window (top=bottom, left=right, lines≥1): one FILL, then DONE.

Decomposition:
- Package scroll_pkg: state enum, direction constants DIR_UP/DIR_DOWN, default screen bounds (rows 0..16, cols 0..59).
- One sub-module, scroll_walker: a row/col cursor with load/step/last-cell flag, shared direction-aware traversal. It is reused later by the clear-screen block.

Test Plan:
- Full screen up: top=0, bottom=16, left=0, right=59, lines=1, fill=0x00, VRAM preloaded cell=row → row r holds r+1 for r<16, row 16 all 0x00. Busy for exactly 1980 cycles, then a single o_done pulse.
- Window down: top=3, bottom=6, left=10, right=12, lines=2, fill=0x20 → rows 5,6 take old rows 3,4 in cols 10..12. Rows 3,4 cols 10..12 become 0x20. Cells outside the window are untouched. 12+6=18 busy cycles.
- Clear: lines=5 on a 4-row window → all cells become i_fill. No READ cycles (o_vram_w high on every busy cycle).
- Invalid: top=7, bottom=3 → o_running never rises, o_vram_ce stays 0, o_done pulses one cycle after start.
- Busy/args: assert i_start and change i_top mid-run → no restart, result matches the originally latched arguments, exactly one o_done.
- Reset mid-run: pull i_rst_n low at cycle 100 → o_running, o_vram_w and o_vram_ce drop immediately, no o_done. A new start after reset completes correctly.
